// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: memory-handshake freezes,
// load-use bubbles, EX redirect flushes, plus saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic             ex_redirect,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_rst,
  output logic             idex_rst,
  output logic             exmem_rst,
  output logic             memwb_rst,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN,
    MSTALL
  } state_t;

  state_t state;
  logic   i_done;
  logic   d_done;
  logic   i_wait;
  logic   d_wait;
  logic   mem_wait;
  logic   load_use;
  logic   do_flush;
  logic   do_bubble;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A side is waiting only while its request is up and its response has neither
  // arrived this cycle nor been captured earlier in the same stall.
  assign i_wait   = imem_read & ~imem_resp & ~i_done;
  assign d_wait   = dmem_req & ~dmem_resp & ~d_done;
  assign mem_wait = i_wait | d_wait;

  assign load_use = idex_mem_read & (idex_rd != '0) &
                    ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
                     (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));

  assign do_flush  = ~mem_wait & ex_redirect;
  assign do_bubble = ~mem_wait & ~ex_redirect & load_use;

  always_comb begin
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    exmem_load = 1'b0;
    memwb_load = 1'b0;
    ifid_rst   = 1'b0;
    idex_rst   = 1'b0;
    exmem_rst  = 1'b0;
    memwb_rst  = 1'b0;
    if (rst) begin
      ifid_rst  = 1'b1;
      idex_rst  = 1'b1;
      exmem_rst = 1'b1;
      memwb_rst = 1'b1;
    end else if (mem_wait) begin
      pc_load = 1'b0;
    end else if (ex_redirect) begin
      pc_load    = 1'b1;
      ifid_load  = 1'b1;
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      ifid_rst   = 1'b1;
      idex_rst   = 1'b1;
    end else if (load_use) begin
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      idex_rst   = 1'b1;
    end else begin
      pc_load    = 1'b1;
      ifid_load  = 1'b1;
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
    end
  end

  // Responses are single-cycle pulses, so they are remembered until the advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      state <= mem_wait ? MSTALL : RUN;
      if (mem_wait) begin
        if (imem_read & imem_resp) i_done <= 1'b1;
        if (dmem_req & dmem_resp)  d_done <= 1'b1;
      end else begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
    end
  end

  assign stalled = (state == MSTALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (mem_wait && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 1'b1;
      if (do_bubble && bubble_count != CNT_MAX)
        bubble_count <= bubble_count + 1'b1;
      if (do_flush && flush_count != CNT_MAX)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
